// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multicycle MIPS-subset core sharing one memory port for instructions and data
module multicycle_datapath #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALU_WB, ADDI_EX, BRANCH, JUMP, HALT
  } state_t;
  state_t            r_state;
  logic [31:0]       r_pc, r_ir, r_mdr, r_a, r_b, r_alu_out;
  logic              r_halted;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_rf [32];
  logic [5:0]        w_op, w_fn;
  logic [4:0]        w_rs, w_rt, w_rd, w_waddr;
  logic [31:0]       w_imm, w_rs_val, w_rt_val, w_alu, w_diff, w_wdata;
  logic              w_rtype_ok, w_taken, w_rf_we, w_retire;
  state_t            w_dec;
  assign w_op       = r_ir[31:26];
  assign w_fn       = r_ir[5:0];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_imm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
  assign w_rtype_ok = (w_fn == 6'h20) || (w_fn == 6'h22) || (w_fn == 6'h24) || (w_fn == 6'h25) || (w_fn == 6'h2A);
  assign w_diff     = r_a - r_b;
  assign w_taken    = (w_op == 6'h04) ? (w_diff == 32'd0) : (w_diff != 32'd0);
  assign w_rf_we    = (r_state == MEMWB) || (r_state == ALU_WB);
  assign w_waddr    = (r_state == ALU_WB && w_op == 6'h00) ? w_rd : w_rt;
  assign w_wdata    = (r_state == MEMWB) ? r_mdr : r_alu_out;
  assign w_retire   = (r_state == MEMWB) || (r_state == ALU_WB) || (r_state == BRANCH) ||
                      (r_state == JUMP) || (r_state == MEMWR && mem_ready);
  // R-type ALU result; anything not add/sub/and/or is slt since unsupported functs never reach RTYPE_EX
  always_comb
    w_alu = (w_fn == 6'h20) ? r_a + r_b :
            (w_fn == 6'h22) ? r_a - r_b :
            (w_fn == 6'h24) ? r_a & r_b :
            (w_fn == 6'h25) ? r_a | r_b :
            {31'd0, $signed(r_a) < $signed(r_b)};
  // opcode decode into the next state after DECODE
  always_comb
    w_dec = (w_op == 6'h00) ? (w_rtype_ok ? RTYPE_EX : HALT) :
            (w_op == 6'h23 || w_op == 6'h2B) ? MEMADR :
            (w_op == 6'h04 || w_op == 6'h05) ? BRANCH :
            (w_op == 6'h08) ? ADDI_EX :
            (w_op == 6'h02) ? JUMP : HALT;
  // memory port driven from registered state; reset masks the request so nothing completes while in reset
  assign mem_req     = !reset && (r_state == FETCH || r_state == MEMRD || r_state == MEMWR);
  assign mem_we      = (r_state == MEMWR);
  assign mem_addr    = (r_state == FETCH) ? r_pc[ADDR_W-1:0] : r_alu_out[ADDR_W-1:0];
  assign mem_wdata   = r_b;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign instr_count = r_count;
  // register file write port; contents survive reset, register 0 is never written
  always_ff @(posedge clk)
    if (!reset && w_rf_we && w_waddr != 5'd0) r_rf[w_waddr] <= w_wdata;
  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_halted  <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_retire) r_count <= r_count + CNT_W'(1);
      case (r_state)
        FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + 32'd4;
          r_state <= DECODE;
        end
        DECODE: begin
          r_a       <= w_rs_val;
          r_b       <= w_rt_val;
          r_alu_out <= r_pc + (w_imm << 2);
          r_halted  <= (w_dec == HALT);
          r_state   <= w_dec;
        end
        MEMADR: begin
          r_alu_out <= r_a + w_imm;
          r_state   <= (w_op == 6'h23) ? MEMRD : MEMWR;
        end
        MEMRD: if (mem_ready) begin
          r_mdr   <= mem_rdata;
          r_state <= MEMWB;
        end
        MEMWB: r_state <= FETCH;
        MEMWR: if (mem_ready) r_state <= FETCH;
        RTYPE_EX: begin
          r_alu_out <= w_alu;
          r_state   <= ALU_WB;
        end
        ADDI_EX: begin
          r_alu_out <= r_a + w_imm;
          r_state   <= ALU_WB;
        end
        ALU_WB: r_state <= FETCH;
        BRANCH: begin
          if (w_taken) r_pc <= r_alu_out;
          r_state <= FETCH;
        end
        JUMP: begin
          r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
          r_state <= FETCH;
        end
        HALT: r_state <= HALT;
        default: r_state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: scoreboard bench checking memory transactions and core status of multicycle_datapath
module tb_multicycle_datapath;
  logic        clk, reset, mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr_count;
  logic [31:0] mem [256];
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t sb[$];
  int n_tests = 0, n_fail = 0;
  localparam logic [31:0] HALTW = 32'hFC00_0000;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .halted(halted), .instr_count(instr_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] = mem_wdata;

  function automatic logic [31:0] rt(input logic [4:0] rs, input logic [4:0] rtt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rtt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rtt, input logic [15:0] imm);
    return {op, rs, rtt, imm};
  endfunction
  function automatic logic [31:0] jt(input logic [31:0] a);
    return {6'h02, a[27:2]};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask
  task automatic exp_rd(input logic [31:0] a);
    sb.push_back('{1'b0, a, 32'd0});
  endtask
  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{1'b1, a, d});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: every completing memory transaction must match the next expected one
  initial forever begin
    @(negedge clk);
    if (mem_req && mem_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mem_txn: unexpected we=%0d addr=%h data=%h", mem_we, mem_addr, mem_wdata);
      end else begin
        txn_t e;
        e = sb.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
          n_fail++;
          $display("FAIL mem_txn: got we=%0d addr=%h data=%h, expected we=%0d addr=%h data=%h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    bit done;
    for (int i = 0; i < 256; i++) mem[i] = HALTW;
    put(32'h00, it(6'h08, 0, 1, 16'd5));
    put(32'h04, it(6'h08, 0, 2, 16'd7));
    put(32'h08, rt(1, 2, 3, 6'h20));
    put(32'h0C, it(6'h2B, 0, 3, 16'h40));
    put(32'h10, it(6'h04, 1, 1, 16'd2));
    put(32'h1C, it(6'h23, 0, 4, 16'h40));
    put(32'h20, it(6'h2B, 0, 4, 16'h44));
    put(32'h24, it(6'h05, 1, 1, 16'd2));
    put(32'h28, rt(2, 1, 5, 6'h22));
    put(32'h2C, it(6'h2B, 0, 5, 16'h48));
    put(32'h30, it(6'h08, 0, 6, 16'hFFFF));
    put(32'h34, jt(32'h100));
    put(32'h100, rt(6, 1, 7, 6'h2A));
    put(32'h104, it(6'h2B, 0, 7, 16'h4C));
    put(32'h108, rt(1, 2, 8, 6'h24));
    put(32'h10C, rt(1, 2, 9, 6'h25));
    put(32'h110, it(6'h2B, 0, 8, 16'h50));
    put(32'h114, it(6'h2B, 0, 9, 16'h54));
    put(32'h118, rt(1, 6, 10, 6'h2A));
    put(32'h11C, rt(6, 6, 11, 6'h20));
    put(32'h120, it(6'h2B, 0, 10, 16'h58));
    put(32'h124, it(6'h2B, 0, 11, 16'h5C));
    put(32'h128, rt(1, 2, 0, 6'h20));
    put(32'h12C, it(6'h2B, 0, 0, 16'h60));
    exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h08);
    exp_rd(32'h0C); exp_wr(32'h40, 32'd12);
    exp_rd(32'h10); exp_rd(32'h1C); exp_rd(32'h40);
    exp_rd(32'h20); exp_wr(32'h44, 32'd12);
    exp_rd(32'h24); exp_rd(32'h28);
    exp_rd(32'h2C); exp_wr(32'h48, 32'd2);
    exp_rd(32'h30); exp_rd(32'h34); exp_rd(32'h100);
    exp_rd(32'h104); exp_wr(32'h4C, 32'd1);
    exp_rd(32'h108); exp_rd(32'h10C);
    exp_rd(32'h110); exp_wr(32'h50, 32'd5);
    exp_rd(32'h114); exp_wr(32'h54, 32'd7);
    exp_rd(32'h118); exp_rd(32'h11C);
    exp_rd(32'h120); exp_wr(32'h58, 32'd0);
    exp_rd(32'h124); exp_wr(32'h5C, 32'hFFFF_FFFE);
    exp_rd(32'h128);
    exp_rd(32'h12C); exp_wr(32'h60, 32'd0);
    exp_rd(32'h130);
    reset = 1; mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    reset = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("count_12cyc", instr_count, 32'd3);
    chk("pc_12cyc", pc, 32'h0C);
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      #1;
      done = halted;
    end
    chk("halt_reached", {31'd0, done}, 32'd1);
    chk("halt_pc", pc, 32'h134);
    chk("halt_count", instr_count, 32'd24);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("halt_frozen", {halted, mem_req, pc[29:0]}, {2'b10, 30'h134});
    end
    chk("sb_empty_1", sb.size(), 32'd0);
    reset = 1;
    @(posedge clk);
    #1;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_count", instr_count, 32'd0);
    chk("rst2_req", {31'd0, mem_req}, 32'd0);
    exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h08); exp_rd(32'h0C);
    mem_ready = 0;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_bus", {mem_req, mem_we, mem_addr[29:0]}, {2'b10, 30'h0});
    end
    @(posedge clk);
    #1;
    chk("stall_pc_held", pc, 32'h0);
    mem_ready = 1;
    @(posedge clk);
    #1;
    chk("stall_done_pc", pc, 32'h4);
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #1;
      done = mem_we;
    end
    chk("memwr_reached", {31'd0, done}, 32'd1);
    chk("memwr_count", instr_count, 32'd3);
    reset = 1;
    @(posedge clk);
    #1;
    chk("memwr_rst_count", instr_count, 32'd0);
    chk("memwr_rst_pc", pc, 32'h0);
    chk("memwr_rst_req", {31'd0, mem_req}, 32'd0);
    mem_ready = 0;
    reset = 0;
    @(negedge clk);
    chk("memwr_rst_fetch", {mem_req, mem_we, mem_addr[29:0]}, {2'b10, 30'h0});
    chk("memwr_no_store", mem[16'h60 >> 2], 32'd0);
    chk("sb_empty_2", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
